// File: rtl/k005297_mskrcv.sv
// Serial word receiver: assembles LSB-first bits into 4- or 16-bit words,
// paced by an active-low bit-rate enable, and holds each result until acknowledged.
module k005297_mskrcv (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_CLK2M_PCEN_n,
  input  logic        i_4BEN_n,
  input  logic        i_FRAME_START,
  input  logic        i_SD,
  input  logic        i_SD_VALID,
  input  logic        i_WORD_ACK,
  output logic [15:0] o_DOUT,
  output logic        o_WORD_VALID,
  output logic        o_OVERRUN,
  output logic        o_BUSY
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] sr;
  logic [3:0]  cnt;
  logic        m4;

  logic        en;
  logic [15:0] sr_shift;
  logic [3:0]  cnt_last;
  logic        bit_in;
  logic        complete;

  assign en       = ~i_CLK2M_PCEN_n;
  assign sr_shift = {i_SD, sr[15:1]};
  assign cnt_last = m4 ? 4'd3 : 4'd15;
  assign bit_in   = en && !i_FRAME_START && (state == RECV) && i_SD_VALID;
  assign complete = bit_in && (cnt == cnt_last);

  // o_BUSY doubles as the observable FSM state: it is high exactly in RECV.
  assign o_BUSY = (state == RECV);

  // Output handshake: o_WORD_VALID rises one i_MCLK after the last bit of a
  // frame is sampled and o_DOUT is stable while it is high; the consumer
  // pulses i_WORD_ACK (any edge, not enable-gated) to drop it. A word that
  // completes on the same edge as the ack wins and stays valid.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state        <= IDLE;
      sr           <= 16'h0000;
      cnt          <= 4'd0;
      m4           <= 1'b0;
      o_DOUT       <= 16'h0000;
      o_WORD_VALID <= 1'b0;
      o_OVERRUN    <= 1'b0;
    end else begin
      if (i_WORD_ACK) begin
        o_WORD_VALID <= 1'b0;
      end
      if (en) begin
        if (i_FRAME_START) begin
          // Start or restart: the concurrent bit, if any, is bit 0 of the new frame.
          state <= RECV;
          m4    <= ~i_4BEN_n;
          if (i_SD_VALID) begin
            sr  <= sr_shift;
            cnt <= 4'd1;
          end else begin
            cnt <= 4'd0;
          end
        end else if (bit_in) begin
          sr <= sr_shift;
          if (complete) begin
            o_DOUT       <= m4 ? {12'h000, i_SD, sr[15:13]} : sr_shift;
            o_WORD_VALID <= 1'b1;
            if (o_WORD_VALID && !i_WORD_ACK) begin
              o_OVERRUN <= 1'b1;
            end
            cnt   <= 4'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      end
    end
  end

endmodule
